// File: rtl/riscv_ctrl_fsm.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | riscv_ctrl_fsm                                                         |
// | Multi-cycle RV32I control FSM (R, I, LW, SW, BR) with memory stall.    |
// | Optional: define CTRL_PERF_EN for the instret retirement counter.      |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module riscv_ctrl_fsm #(
  parameter bit ILLEGAL_TRAP = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic [3:0]  status,
  input  logic        mem_ready,
  output logic        regRW,
  output logic        ALUsrc,
  output logic [1:0]  immsrc,
  output logic [4:0]  ALUop,
  output logic        mRW,
  output logic        wb,
  output logic        pcsrc,
  output logic        pcen,
  output logic        ir_ld,
  output logic        trap,
  output logic [2:0]  state,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  state_t      r_state;
  logic [31:0] r_ir;
  logic        r_trap;

  logic [6:0] w_op;
  logic [2:0] w_f3;
  logic       w_is_r, w_is_i, w_is_lw, w_is_sw, w_is_br, w_legal;
  logic       w_taken;
  logic       w_alusrc;
  logic [1:0] w_immsrc;
  logic [4:0] w_aluop;
  logic       w_unused_ir;

  assign w_op        = r_ir[6:0];
  assign w_f3        = r_ir[14:12];
  assign w_unused_ir = ^{r_ir[31], r_ir[29:15], r_ir[11:7]};

  assign w_is_r  = (w_op == 7'b0110011);
  assign w_is_i  = (w_op == 7'b0010011);
  assign w_is_lw = (w_op == 7'b0000011) && (w_f3 == 3'b010);
  assign w_is_sw = (w_op == 7'b0100011) && (w_f3 == 3'b010);
  assign w_is_br = (w_op == 7'b1100011) && (w_f3 != 3'b010) && (w_f3 != 3'b011);
  assign w_legal = w_is_r | w_is_i | w_is_lw | w_is_sw | w_is_br;

  // status = {N,Z,C,V}; carry set means no borrow on the subtract
  always_comb begin
    w_taken = 1'b0;
    case (w_f3)
      3'b000:  w_taken = status[2];
      3'b001:  w_taken = ~status[2];
      3'b100:  w_taken = status[3] ^ status[0];
      3'b101:  w_taken = ~(status[3] ^ status[0]);
      3'b110:  w_taken = ~status[1];
      3'b111:  w_taken = status[1];
      default: w_taken = 1'b0;
    endcase
  end

  always_comb begin
    w_alusrc = 1'b0;
    w_immsrc = 2'b00;
    w_aluop  = 5'b00000;
    if (w_is_r) begin
      w_alusrc = 1'b1;
      w_aluop  = {1'b0, r_ir[30], w_f3};
    end else if (w_is_i) begin
      w_aluop  = {1'b0, (w_f3 == 3'b101) & r_ir[30], w_f3};
    end else if (w_is_sw) begin
      w_immsrc = 2'b01;
    end else if (w_is_br) begin
      w_alusrc = 1'b1;
      w_immsrc = 2'b10;
      w_aluop  = 5'b01000;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_ir    <= 32'd0;
      r_trap  <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (mem_ready) begin
            r_ir    <= instr;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (w_legal) begin
            r_state <= S_EXEC;
          end else if (ILLEGAL_TRAP) begin
            r_state <= S_TRAP;
            r_trap  <= 1'b1;
          end else begin
            r_state <= S_FETCH;
          end
        end
        S_EXEC: begin
          if (w_is_br)                r_state <= S_FETCH;
          else if (w_is_lw | w_is_sw) r_state <= S_MEM;
          else                        r_state <= S_WB;
        end
        S_MEM: begin
          if (mem_ready) r_state <= w_is_sw ? S_FETCH : S_WB;
        end
        S_WB:    r_state <= S_FETCH;
        S_TRAP:  r_state <= S_TRAP;
        default: r_state <= S_FETCH;
      endcase
    end
  end

  // Everything is forced low while rst is asserted, including mid-instruction
  always_comb begin
    regRW  = 1'b0;
    ALUsrc = 1'b0;
    immsrc = 2'b00;
    ALUop  = 5'b00000;
    mRW    = 1'b0;
    wb     = 1'b0;
    pcsrc  = 1'b0;
    pcen   = 1'b0;
    ir_ld  = 1'b0;
    if (!rst) begin
      case (r_state)
        S_FETCH:  ir_ld = mem_ready;
        S_DECODE: pcen  = ~w_legal & ~ILLEGAL_TRAP;
        S_EXEC: begin
          ALUsrc = w_alusrc;
          immsrc = w_immsrc;
          ALUop  = w_aluop;
          if (w_is_br) begin
            pcen  = 1'b1;
            pcsrc = w_taken;
          end
        end
        S_MEM: begin
          ALUsrc = w_alusrc;
          immsrc = w_immsrc;
          ALUop  = w_aluop;
          mRW    = w_is_sw;
          pcen   = w_is_sw & mem_ready;
        end
        S_WB: begin
          ALUsrc = w_alusrc;
          immsrc = w_immsrc;
          ALUop  = w_aluop;
          regRW  = 1'b1;
          pcen   = 1'b1;
          wb     = w_is_lw;
        end
        default: ;
      endcase
    end
  end

  assign state = rst ? 3'd0 : r_state;
  assign trap  = rst ? 1'b0 : r_trap;

`ifdef CTRL_PERF_EN
  logic [31:0] r_instret;

  always_ff @(posedge clk) begin
    if (rst)       r_instret <= 32'd0;
    else if (pcen) r_instret <= r_instret + 32'd1;
  end

  assign instret = rst ? 32'd0 : r_instret;
`else
  assign instret = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_riscv_ctrl_fsm.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_riscv_ctrl_fsm                                                      |
// | Bench for riscv_ctrl_fsm: trapping and NOP-retiring builds side by side.|
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_riscv_ctrl_fsm;

  localparam int c_r = 0, c_i = 1, c_lw = 2, c_sw = 3, c_br = 4, c_ill = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic [3:0]  status;
  logic        mem_ready;

  logic        regRW  [0:1];
  logic        ALUsrc [0:1];
  logic [1:0]  immsrc [0:1];
  logic [4:0]  ALUop  [0:1];
  logic        mRW    [0:1];
  logic        wb     [0:1];
  logic        pcsrc  [0:1];
  logic        pcen   [0:1];
  logic        ir_ld  [0:1];
  logic        trap   [0:1];
  logic [2:0]  state  [0:1];
  logic [31:0] instret[0:1];

  int          nchk = 0;
  int          npass = 0;
  logic [31:0] exp_ir [0:1];

  always #5 clk = ~clk;

  riscv_ctrl_fsm #(.ILLEGAL_TRAP(1'b1)) u_trap (
    .clk(clk), .rst(rst), .instr(instr), .status(status), .mem_ready(mem_ready),
    .regRW(regRW[0]), .ALUsrc(ALUsrc[0]), .immsrc(immsrc[0]), .ALUop(ALUop[0]),
    .mRW(mRW[0]), .wb(wb[0]), .pcsrc(pcsrc[0]), .pcen(pcen[0]), .ir_ld(ir_ld[0]),
    .trap(trap[0]), .state(state[0]), .instret(instret[0])
  );

  riscv_ctrl_fsm #(.ILLEGAL_TRAP(1'b0)) u_nop (
    .clk(clk), .rst(rst), .instr(instr), .status(status), .mem_ready(mem_ready),
    .regRW(regRW[1]), .ALUsrc(ALUsrc[1]), .immsrc(immsrc[1]), .ALUop(ALUop[1]),
    .mRW(mRW[1]), .wb(wb[1]), .pcsrc(pcsrc[1]), .pcen(pcen[1]), .ir_ld(ir_ld[1]),
    .trap(trap[1]), .state(state[1]), .instret(instret[1])
  );

  // {regRW, ALUsrc, immsrc, ALUop, mRW, wb, pcsrc, pcen, ir_ld, trap, state}
  function automatic logic [17:0] mk(input logic rw, input logic src, input logic [1:0] imm,
                                     input logic [4:0] op, input logic mrw, input logic wbv,
                                     input logic psrc, input logic pen, input logic irl,
                                     input logic trp, input logic [2:0] st);
    return {rw, src, imm, op, mrw, wbv, psrc, pen, irl, trp, st};
  endfunction

  function automatic logic [49:0] act(input int k);
    return {regRW[k], ALUsrc[k], immsrc[k], ALUop[k], mRW[k], wb[k], pcsrc[k],
            pcen[k], ir_ld[k], trap[k], state[k], instret[k]};
  endfunction

  function automatic int cls_of(input logic [31:0] ins);
    logic [2:0] f3;
    f3 = ins[14:12];
    case (ins[6:0])
      7'b0110011: return c_r;
      7'b0010011: return c_i;
      7'b0000011: return (f3 == 3'b010) ? c_lw : c_ill;
      7'b0100011: return (f3 == 3'b010) ? c_sw : c_ill;
      7'b1100011: return (f3 == 3'b010 || f3 == 3'b011) ? c_ill : c_br;
      default:    return c_ill;
    endcase
  endfunction

  // {ALUsrc, immsrc, ALUop} expected for a legal instruction
  function automatic logic [7:0] alu_exp(input logic [31:0] ins);
    logic [2:0] f3;
    f3 = ins[14:12];
    case (cls_of(ins))
      c_r:     return {1'b1, 2'b00, 1'b0, ins[30], f3};
      c_i:     return {1'b0, 2'b00, 1'b0, (f3 == 3'b101) ? ins[30] : 1'b0, f3};
      c_sw:    return {1'b0, 2'b01, 5'b00000};
      c_br:    return {1'b1, 2'b10, 5'b01000};
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic taken_exp(input logic [31:0] ins, input logic [3:0] st);
    logic n, z, c, v;
    {n, z, c, v} = st;
    case (ins[14:12])
      3'b000:  return z;
      3'b001:  return !z;
      3'b100:  return n != v;
      3'b101:  return n == v;
      3'b110:  return !c;
      default: return c;
    endcase
  endfunction

  task automatic check(input string nm, input logic [17:0] e0, input logic [17:0] e1);
    logic [49:0] a, e;
    for (int k = 0; k < 2; k++) begin
      e = {(k == 0) ? e0 : e1, exp_ir[k]};
      a = act(k);
      nchk++;
      if (a === e) npass++;
      else $display("FAIL %s dut%0d: got %h expected %h", nm, k, a, e);
`ifdef CTRL_PERF_EN
      if (e[37]) exp_ir[k] = exp_ir[k] + 32'd1;
`endif
    end
  endtask

  task automatic check_val(input string nm, input logic [31:0] a, input logic [31:0] e);
    nchk++;
    if (a === e) npass++;
    else $display("FAIL %s: got %h expected %h", nm, a, e);
  endtask

  task automatic cyc(input logic mr, input string nm, input logic [17:0] e0, input logic [17:0] e1);
    @(negedge clk);
    mem_ready = mr;
    #1;
    check(nm, e0, e1);
  endtask

  task automatic do_reset(input int n);
    exp_ir[0] = 32'd0;
    exp_ir[1] = 32'd0;
    repeat (n) begin
      @(negedge clk);
      rst = 1'b1;
      mem_ready = 1'($urandom_range(0, 1));
      #1;
      check("reset_zero", 18'd0, 18'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    mem_ready = 1'b0;
    #1;
    check("post_reset", 18'd0, 18'd0);
  endtask

  task automatic run_instr(input logic [31:0] ins, input logic [3:0] st, input int fst,
                           input int mst, output int ncyc, output logic [7:0] obs_alu,
                           output logic obs_pcsrc);
    int          c;
    logic [7:0]  a;
    logic [17:0] e;
    logic        tk;
    instr  = ins;
    status = st;
    c      = cls_of(ins);
    a      = alu_exp(ins);
    tk     = (c == c_br) ? taken_exp(ins, st) : 1'b0;
    ncyc   = 0;
    repeat (fst) begin
      cyc(1'b0, "fetch_stall", mk(0,0,2'b00,5'd0,0,0,0,0,0,0,3'd0), mk(0,0,2'b00,5'd0,0,0,0,0,0,0,3'd0));
      ncyc++;
    end
    e = mk(0,0,2'b00,5'd0,0,0,0,0,1,0,3'd0);
    cyc(1'b1, "fetch", e, e);
    ncyc++;
    e = mk(0,0,2'b00,5'd0,0,0,0,0,0,0,3'd1);
    cyc(1'($urandom_range(0, 1)), "decode", e, e);
    ncyc++;
    e = mk(0, a[7], a[6:5], a[4:0], 0, 0, tk, c == c_br, 0, 0, 3'd2);
    cyc(1'($urandom_range(0, 1)), "exec", e, e);
    obs_alu   = {ALUsrc[0], immsrc[0], ALUop[0]};
    obs_pcsrc = pcsrc[0];
    ncyc++;
    if (c == c_lw || c == c_sw) begin
      e = mk(0, a[7], a[6:5], a[4:0], c == c_sw, 0, 0, 0, 0, 0, 3'd3);
      repeat (mst) begin
        cyc(1'b0, "mem_stall", e, e);
        ncyc++;
      end
      e = mk(0, a[7], a[6:5], a[4:0], c == c_sw, 0, 0, c == c_sw, 0, 0, 3'd3);
      cyc(1'b1, "mem", e, e);
      ncyc++;
    end
    if (c == c_r || c == c_i || c == c_lw) begin
      e = mk(1, a[7], a[6:5], a[4:0], 0, c == c_lw, 0, 1, 0, 0, 3'd4);
      cyc(1'($urandom_range(0, 1)), "wb", e, e);
      ncyc++;
    end
  endtask

  task automatic ill_seq(input logic [31:0] ins);
    logic [17:0] z0, tr;
    z0 = mk(0,0,2'b00,5'd0,0,0,0,0,0,0,3'd0);
    tr = mk(0,0,2'b00,5'd0,0,0,0,0,0,1,3'd7);
    instr = ins;
    cyc(1'b1, "ill_fetch", mk(0,0,2'b00,5'd0,0,0,0,0,1,0,3'd0), mk(0,0,2'b00,5'd0,0,0,0,0,1,0,3'd0));
    cyc(1'b0, "ill_decode", mk(0,0,2'b00,5'd0,0,0,0,0,0,0,3'd1), mk(0,0,2'b00,5'd0,0,0,0,1,0,0,3'd1));
    repeat (3) cyc(1'b0, "ill_after", tr, z0);
    cyc(1'b1, "ill_sticky", tr, mk(0,0,2'b00,5'd0,0,0,0,0,1,0,3'd0));
    do_reset(1);
  endtask

  typedef struct {
    logic [31:0] ins;
    logic [3:0]  st;
    int          mst;
    int          cyc;
    logic [7:0]  alu;
    logic        pcsrc;
  } vec_t;

  vec_t tbl [15];

  initial begin
    int          n;
    logic [7:0]  oa;
    logic        op;
    logic [31:0] r, ins;
    logic [2:0]  bf [6];

    tbl[0]  = '{32'h002081B3, 4'b0000, 0, 4, 8'h80, 1'b0};  // add
    tbl[1]  = '{32'h402081B3, 4'b0000, 0, 4, 8'h88, 1'b0};  // sub
    tbl[2]  = '{32'h0080A283, 4'b0000, 3, 8, 8'h00, 1'b0};  // lw, 3 stalls
    tbl[3]  = '{32'h0050A223, 4'b0000, 0, 4, 8'h20, 1'b0};  // sw
    tbl[4]  = '{32'h00208463, 4'b0100, 0, 3, 8'hC8, 1'b1};  // beq taken
    tbl[5]  = '{32'h00208463, 4'b0000, 0, 3, 8'hC8, 1'b0};  // beq not taken
    tbl[6]  = '{32'h40315093, 4'b0000, 0, 4, 8'h0D, 1'b0};  // srai
    tbl[7]  = '{32'h40010093, 4'b0000, 0, 4, 8'h00, 1'b0};  // addi, bit30 ignored
    tbl[8]  = '{32'h0020E463, 4'b0000, 0, 3, 8'hC8, 1'b1};  // bltu, C=0
    tbl[9]  = '{32'h0020E463, 4'b0010, 0, 3, 8'hC8, 1'b0};  // bltu, C=1
    tbl[10] = '{32'h0020C463, 4'b1000, 0, 3, 8'hC8, 1'b1};  // blt, N^V
    tbl[11] = '{32'h0020D463, 4'b1001, 0, 3, 8'hC8, 1'b1};  // bge, N==V
    tbl[12] = '{32'h00209463, 4'b0100, 0, 3, 8'hC8, 1'b0};  // bne, Z=1
    tbl[13] = '{32'h0050A223, 4'b0000, 2, 6, 8'h20, 1'b0};  // sw, 2 stalls
    tbl[14] = '{32'h0020C1B3, 4'b0000, 0, 4, 8'h84, 1'b0};  // xor

    rst = 1'b1;
    instr = 32'd0;
    status = 4'd0;
    mem_ready = 1'b0;
    do_reset(2);

    for (int i = 0; i < 15; i++) begin
      run_instr(tbl[i].ins, tbl[i].st, 0, tbl[i].mst, n, oa, op);
      check_val($sformatf("tbl%0d_cycles", i), n, tbl[i].cyc);
      check_val($sformatf("tbl%0d_exec_alu", i), {24'd0, oa}, {24'd0, tbl[i].alu});
      check_val($sformatf("tbl%0d_pcsrc", i), {31'd0, op}, {31'd0, tbl[i].pcsrc});
    end

    // reset abandons an LW stalled in MEM
    instr = 32'h0080A283;
    cyc(1'b1, "rlw_fetch", mk(0,0,2'b00,5'd0,0,0,0,0,1,0,3'd0), mk(0,0,2'b00,5'd0,0,0,0,0,1,0,3'd0));
    cyc(1'b0, "rlw_decode", mk(0,0,2'b00,5'd0,0,0,0,0,0,0,3'd1), mk(0,0,2'b00,5'd0,0,0,0,0,0,0,3'd1));
    cyc(1'b0, "rlw_exec", mk(0,0,2'b00,5'd0,0,0,0,0,0,0,3'd2), mk(0,0,2'b00,5'd0,0,0,0,0,0,0,3'd2));
    cyc(1'b0, "rlw_mem", mk(0,0,2'b00,5'd0,0,0,0,0,0,0,3'd3), mk(0,0,2'b00,5'd0,0,0,0,0,0,0,3'd3));
    do_reset(2);

    ill_seq(32'hFFFFFFFF);
    ill_seq(32'h00008083);  // lb: unsupported funct3
    ill_seq(32'h0020A463);  // branch funct3 010

    bf = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};
    for (int i = 0; i < 300; i++) begin
      r = $urandom;
      case ($urandom_range(0, 4))
        0:       ins = {r[31:7], 7'b0110011};
        1:       ins = {r[31:7], 7'b0010011};
        2:       ins = {r[31:15], 3'b010, r[11:7], 7'b0000011};
        3:       ins = {r[31:15], 3'b010, r[11:7], 7'b0100011};
        default: ins = {r[31:15], bf[$urandom_range(0, 5)], r[11:7], 7'b1100011};
      endcase
      run_instr(ins, 4'($urandom_range(0, 15)), $urandom_range(0, 2), $urandom_range(0, 3), n, oa, op);
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
`default_nettype wire
